// File: rtl/add_ctrl_pkg.sv
// Shared types and default sizing for the multi-word add controller.
package add_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CHUNK_W_DEF    = 8;
    localparam int NUM_CHUNKS_DEF = 4;
endpackage

// File: rtl/param_full_adder.sv
// Parameterized ripple-carry adder; the result is one bit wider than the operands.
module param_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   y
);
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign y[WIDTH] = c[WIDTH];
endmodule

// File: rtl/multiword_add_ctrl.sv
// Wide unsigned adder built from one narrow adder, stepped LSB chunk first,
// with valid/ready on both sides and optional saturation on overflow.
module multiword_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int CHUNK_W    = CHUNK_W_DEF,
    parameter int NUM_CHUNKS = NUM_CHUNKS_DEF,
    localparam int TOTAL_W   = CHUNK_W * NUM_CHUNKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] op_a,
    input  logic [TOTAL_W-1:0] op_b,
    input  logic               sat_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] sum,
    output logic               carry_out,
    output logic               saturated,
    output logic               busy
);
    localparam int IDX_W = $clog2(NUM_CHUNKS);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [TOTAL_W-1:0] a_q, b_q;
    logic               sat_q;

    logic [CHUNK_W-1:0] a_ch, b_ch, ch_sum;
    logic [CHUNK_W+1:0] add_y;
    logic               ch_co, last;
    logic               unused_lsb;

    assign a_ch = a_q[idx*CHUNK_W +: CHUNK_W];
    assign b_ch = b_q[idx*CHUNK_W +: CHUNK_W];

    // Carry-in rides in the LSB of both operands: c+c produces carry c into bit 1.
    param_full_adder #(.WIDTH(CHUNK_W + 1)) u_add (
        .a ({a_ch, carry}),
        .b ({b_ch, carry}),
        .y (add_y)
    );

    assign ch_sum     = add_y[CHUNK_W:1];
    assign ch_co      = add_y[CHUNK_W+1];
    assign unused_lsb = add_y[0];
    assign last       = (idx == IDX_W'(NUM_CHUNKS - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sat_q     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            saturated <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q       <= op_a;
                    b_q       <= op_b;
                    sat_q     <= sat_en;
                    idx       <= '0;
                    carry     <= 1'b0;
                    sum       <= '0;
                    carry_out <= 1'b0;
                    saturated <= 1'b0;
                end
                RUN: begin
                    sum[idx*CHUNK_W +: CHUNK_W] <= ch_sum;
                    carry <= ch_co;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        idx       <= '0;
                        carry_out <= ch_co;
                        // Later NBA overrides the chunk write when clamping.
                        if (sat_q && ch_co) begin
                            sum       <= '1;
                            saturated <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
